// File: rtl/alu_adder_pkg.sv
// Shared types and constants for the carry-lookahead adder slice.
package alu_adder_pkg;

  localparam int unsigned PFA_MAX_PIPE = 4;
  localparam logic PFA_RESET_VAL_DEFAULT = 1'b0;

  localparam int unsigned PFA_SPG_W = 3;
  localparam int unsigned PFA_STAGE_W = PFA_SPG_W + 1;

  // Per-bit sum/propagate/generate, as consumed by the lookahead carry unit.
  typedef struct packed {
    logic s;
    logic p;
    logic g;
  } pfa_spg_t;

endpackage

// File: rtl/pfa_pipe_stage.sv
// One pipeline stage of the registered adder-cell path: {s,p,g,valid}, async active-high reset.
module pfa_pipe_stage
  import alu_adder_pkg::*;
#(
  parameter logic RESET_VAL = PFA_RESET_VAL_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PFA_STAGE_W-1:0] stageD,
  output logic [PFA_STAGE_W-1:0] stageQ
);

  // Loads every edge; no enable, so in-flight data can never stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageQ <= {PFA_STAGE_W{RESET_VAL}};
    end else begin
      stageQ <= stageD;
    end
  end

endmodule

// File: rtl/partial_full_adder_1b.sv
// 1-bit partial full adder leaf cell: combinational S/P/G, plus an optional
// PIPE_STAGES-deep registered copy built only when PFA_OUTREG_EN is defined.
module partial_full_adder_1b
  import alu_adder_pkg::*;
#(
  parameter int unsigned PIPE_STAGES = 1,
  parameter logic        RESET_VAL   = PFA_RESET_VAL_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  input  logic A,
  input  logic B,
  input  logic CIN,
  output logic S,
  output logic P,
  output logic G
`ifdef PFA_OUTREG_EN
  ,
  input  logic IN_VALID,
  output logic S_Q,
  output logic P_Q,
  output logic G_Q,
  output logic OUT_VALID
`endif
);

  // Propagate is OR: carry-out is formed downstream as G | (P & CIN).
  pfa_spg_t spg;
  assign spg = '{s: A ^ B ^ CIN, p: A | B, g: A & B};

  assign S = spg.s;
  assign P = spg.p;
  assign G = spg.g;

`ifdef PFA_OUTREG_EN
  logic [PFA_STAGE_W-1:0] stageData [PIPE_STAGES+1];
  pfa_spg_t               spgQ;

  assign stageData[0] = {spg, IN_VALID};

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : gStage
    pfa_pipe_stage #(
      .RESET_VAL(RESET_VAL)
    ) uStage (
      .clk   (CLK),
      .rst   (RESET),
      .stageD(stageData[i]),
      .stageQ(stageData[i+1])
    );
  end

  assign spgQ      = pfa_spg_t'(stageData[PIPE_STAGES][PFA_STAGE_W-1:1]);
  assign S_Q       = spgQ.s;
  assign P_Q       = spgQ.p;
  assign G_Q       = spgQ.g;
  assign OUT_VALID = stageData[PIPE_STAGES][0];
`else
  // Clock, reset and pipeline settings are intentionally unused in the pure combinational build.
  logic unusedCfg;
  assign unusedCfg = ^{CLK, RESET, RESET_VAL, 32'(PIPE_STAGES)};
`endif

endmodule

// File: tb/tb_partial_full_adder_1b.sv
// Directed bench for partial_full_adder_1b; pipeline checks run when PFA_OUTREG_EN is defined.
module tb_partial_full_adder_1b;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic p;
    logic g;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;
  logic A, B, CIN;
  logic S, P, G;
`ifdef PFA_OUTREG_EN
  logic IN_VALID;
  logic S_Q, P_Q, G_Q, OUT_VALID;
`endif

  int checks = 0;
  int failures = 0;
  int errS = 0;
  int errP = 0;
  int errG = 0;

  vec_t vecs [8];

  always #5 CLK = ~CLK;

  partial_full_adder_1b #(
    .PIPE_STAGES(2),
    .RESET_VAL  (1'b0)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .A        (A),
    .B        (B),
    .CIN      (CIN),
    .S        (S),
    .P        (P),
    .G        (G)
`ifdef PFA_OUTREG_EN
    ,
    .IN_VALID (IN_VALID),
    .S_Q      (S_Q),
    .P_Q      (P_Q),
    .G_Q      (G_Q),
    .OUT_VALID(OUT_VALID)
`endif
  );

  // kind: 0=S, 1=P, 2=G, 3=other
  task automatic checkBit(input string name, input logic act, input logic exp, input int kind);
    checks++;
    if (act !== exp) begin
      failures++;
      case (kind)
        0: errS++;
        1: errP++;
        2: errG++;
        default: ;
      endcase
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic runTable(input string tag);
    for (int i = 0; i < 8; i++) begin
      A   = vecs[i].a;
      B   = vecs[i].b;
      CIN = vecs[i].cin;
      #10;
      checkBit($sformatf("%s S[%0d]", tag, i), S, vecs[i].s, 0);
      checkBit($sformatf("%s P[%0d]", tag, i), P, vecs[i].p, 1);
      checkBit($sformatf("%s G[%0d]", tag, i), G, vecs[i].g, 2);
    end
  endtask

  initial begin
    //            a     b     cin   s     p     g
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    RESET = 1'b1;
    A = 1'b0;
    B = 1'b0;
    CIN = 1'b0;
`ifdef PFA_OUTREG_EN
    IN_VALID = 1'b0;
    #2;
    checkBit("rst S_Q", S_Q, 1'b0, 3);
    checkBit("rst P_Q", P_Q, 1'b0, 3);
    checkBit("rst G_Q", G_Q, 1'b0, 3);
    checkBit("rst OUT_VALID", OUT_VALID, 1'b0, 3);
`endif

    // Combinational path while reset is held
    runTable("inRst");

    @(negedge CLK);
    RESET = 1'b0;
    runTable("run");

`ifdef PFA_OUTREG_EN
    // One valid 1/1/1 beat through a 2-stage pipe
    @(negedge CLK);
    A = 1'b1; B = 1'b1; CIN = 1'b1; IN_VALID = 1'b1;
    @(negedge CLK);
    A = 1'b0; B = 1'b0; CIN = 1'b0; IN_VALID = 1'b0;
    checkBit("lat1 OUT_VALID", OUT_VALID, 1'b0, 3);
    @(posedge CLK); #1;
    checkBit("lat2 S_Q", S_Q, 1'b1, 3);
    checkBit("lat2 P_Q", P_Q, 1'b1, 3);
    checkBit("lat2 G_Q", G_Q, 1'b1, 3);
    checkBit("lat2 OUT_VALID", OUT_VALID, 1'b1, 3);
    @(posedge CLK); #1;
    checkBit("lat3 S_Q", S_Q, 1'b0, 3);
    checkBit("lat3 P_Q", P_Q, 1'b0, 3);
    checkBit("lat3 G_Q", G_Q, 1'b0, 3);
    checkBit("lat3 OUT_VALID", OUT_VALID, 1'b0, 3);

    // Fill the pipe, then reset asynchronously between edges
    @(negedge CLK);
    A = 1'b1; B = 1'b1; CIN = 1'b1; IN_VALID = 1'b1;
    @(posedge CLK);
    @(posedge CLK); #1;
    checkBit("fill OUT_VALID", OUT_VALID, 1'b1, 3);
    #1;
    RESET = 1'b1;
    #1;
    checkBit("arst S_Q", S_Q, 1'b0, 3);
    checkBit("arst P_Q", P_Q, 1'b0, 3);
    checkBit("arst G_Q", G_Q, 1'b0, 3);
    checkBit("arst OUT_VALID", OUT_VALID, 1'b0, 3);
    @(negedge CLK);
    IN_VALID = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      checkBit($sformatf("post-rst OUT_VALID[%0d]", k), OUT_VALID, 1'b0, 3);
    end
`endif

    $display("mismatch counts S=%0d P=%0d G=%0d", errS, errP, errG);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
